// File: rtl/fifo_hdl_pkg.sv
// Shared helpers for the width splitter/combiner family: sizing math,
// occupancy encoding and the beat-to-bit-offset mapping.
package fifo_hdl_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Beat counter width; at least one bit so NSIZE=2..256 all get a real field.
    function automatic int csize_of(input int nsize);
        return (clog2(nsize) < 1) ? 1 : clog2(nsize);
    endfunction

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    // Bit offset of beat idx in a wide word; matches the combiner's packing.
    function automatic int beat_offset(input int idx, input int dsize,
                                       input int nsize, input int msb_first);
        return (msb_first != 0) ? dsize * (nsize - 1 - idx) : dsize * idx;
    endfunction

endpackage

// File: rtl/fifo_word_buf2.sv
// Two-entry ping-pong word store with registered ready. The head entry is
// read from registered state only, so nothing from the write side reaches it.
module fifo_word_buf2
    import fifo_hdl_pkg::*;
#(
    parameter int WSIZE = 8,
    parameter int CSIZE = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WSIZE-1:0] in_data,
    input  logic [CSIZE-1:0] in_cnt,
    input  logic             in_last,
    input  logic             push,
    output logic             ready,
    input  logic             pop,
    output logic [WSIZE-1:0] head_data,
    output logic [CSIZE-1:0] head_cnt,
    output logic             head_last,
    output logic             head_vld
);

    occ_t occ_reg, occ_next;
    logic wr_ptr_reg;
    logic rd_ptr_reg;
    logic ready_reg;

    logic [WSIZE-1:0] data_mem [2];
    logic [CSIZE-1:0] cnt_mem  [2];
    logic             last_mem [2];

    always_comb begin
        occ_next = occ_reg;
        case (occ_reg)
            EMPTY: if (push) occ_next = ONE;
            ONE: begin
                if (push && !pop)      occ_next = FULL;
                else if (!push && pop) occ_next = EMPTY;
            end
            FULL:  if (pop) occ_next = ONE;
            default: occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg    <= EMPTY;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            occ_reg   <= occ_next;
            ready_reg <= (occ_next != FULL);
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Contents need no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= in_data;
            cnt_mem[wr_ptr_reg]  <= in_cnt;
            last_mem[wr_ptr_reg] <= in_last;
        end
    end

    assign ready     = ready_reg;
    assign head_vld  = (occ_reg != EMPTY);
    assign head_data = data_mem[rd_ptr_reg];
    assign head_cnt  = cnt_mem[rd_ptr_reg];
    assign head_last = last_mem[rd_ptr_reg];

endmodule

// File: rtl/fifo_split.sv
// Width splitter: takes one DSIZE*NSIZE-bit word per handshake and emits
// up to NSIZE DSIZE-bit beats, one per cycle, in the combiner's beat order.
module fifo_split
    import fifo_hdl_pkg::*;
#(
    parameter int  DSIZE     = 1,
    parameter int  NSIZE     = 8,
    parameter int  MSB_FIRST = 1,
    localparam int CSIZE     = csize_of(NSIZE)
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [DSIZE*NSIZE-1:0] wr_data,
    input  logic                   wr_vld,
    output logic                   wr_ready,
    input  logic [CSIZE-1:0]       wr_cnt,
    input  logic                   wr_last,
    output logic [DSIZE-1:0]       rd_data,
    output logic                   rd_vld,
    input  logic                   rd_ready,
    output logic                   rd_align_last,
    output logic                   rd_last
);

    localparam int               WSIZE   = DSIZE * NSIZE;
    localparam logic [CSIZE-1:0] CNT_MAX = CSIZE'(NSIZE - 1);

    logic [CSIZE-1:0] cnt_sat;
    logic             push;
    logic             pop_beat;
    logic             pop_word;
    logic             final_beat;

    logic [WSIZE-1:0] head_data;
    logic [CSIZE-1:0] head_cnt;
    logic             head_last;
    logic             head_vld;

    logic [CSIZE-1:0] beat_reg;
    logic [DSIZE-1:0] beat_data [NSIZE];

    // Out-of-range counts (non-power-of-two NSIZE) collapse to a full word.
    assign cnt_sat = (wr_cnt > CNT_MAX) ? CNT_MAX : wr_cnt;
    assign push    = wr_vld && wr_ready;

    fifo_word_buf2 #(
        .WSIZE (WSIZE),
        .CSIZE (CSIZE)
    ) u_buf (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_data   (wr_data),
        .in_cnt    (cnt_sat),
        .in_last   (wr_last),
        .push      (push),
        .ready     (wr_ready),
        .pop       (pop_word),
        .head_data (head_data),
        .head_cnt  (head_cnt),
        .head_last (head_last),
        .head_vld  (head_vld)
    );

    generate
        for (genvar gi = 0; gi < NSIZE; gi++) begin : g_beat
            localparam int OFF = beat_offset(gi, DSIZE, NSIZE, MSB_FIRST);
            assign beat_data[gi] = head_data[OFF +: DSIZE];
        end
    endgenerate

    assign final_beat = (beat_reg == head_cnt);
    assign pop_beat   = head_vld && rd_ready;
    assign pop_word   = pop_beat && final_beat;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg <= '0;
        end else if (pop_beat) begin
            beat_reg <= final_beat ? '0 : beat_reg + 1'b1;
        end
    end

    // Gate by valid so stale buffer contents never show on rd_data.
    assign rd_vld        = head_vld;
    assign rd_data       = head_vld ? beat_data[beat_reg] : '0;
    assign rd_align_last = head_vld && final_beat;
    assign rd_last       = rd_align_last && head_last;

endmodule

// File: tb/tb_fifo_split.sv
// Directed bench for fifo_split at DSIZE=8, NSIZE=4, MSB_FIRST=1.
module tb_fifo_split;

    logic        clock;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_vld;
    logic        wr_ready;
    logic [1:0]  wr_cnt;
    logic        wr_last;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic        rd_ready;
    logic        rd_align_last;
    logic        rd_last;

    int n_vec;
    int n_err;

    fifo_split #(
        .DSIZE     (8),
        .NSIZE     (4),
        .MSB_FIRST (1)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .wr_data       (wr_data),
        .wr_vld        (wr_vld),
        .wr_ready      (wr_ready),
        .wr_cnt        (wr_cnt),
        .wr_last       (wr_last),
        .rd_data       (rd_data),
        .rd_vld        (rd_vld),
        .rd_ready      (rd_ready),
        .rd_align_last (rd_align_last),
        .rd_last       (rd_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; all sampling and driving happens here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [7:0] data,
                              input logic align, input logic last);
        check({tag, ".vld"}, 32'(rd_vld), 32'd1);
        check({tag, ".data"}, 32'(rd_data), 32'(data));
        check({tag, ".align"}, 32'(rd_align_last), 32'(align));
        check({tag, ".last"}, 32'(rd_last), 32'(last));
    endtask

    logic [31:0] words [3];
    logic        ready_exp [14];
    logic        hs;
    int          w;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_data  = '0;
        wr_vld   = 1'b0;
        wr_cnt   = '0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst.vld", 32'(rd_vld), 32'd0);
        check("rst.ready", 32'(wr_ready), 32'd0);
        check("rst.data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        step();
        check("rel.ready", 32'(wr_ready), 32'd1);
        check("rel.vld", 32'(rd_vld), 32'd0);
        step();

        // Single full word
        wr_data = 32'hAABBCCDD; wr_cnt = 2'd3; wr_last = 1'b1; wr_vld = 1'b1; rd_ready = 1'b1;
        step();
        wr_vld = 1'b0;
        check_beat("single.b0", 8'hAA, 1'b0, 1'b0); step();
        check_beat("single.b1", 8'hBB, 1'b0, 1'b0); step();
        check_beat("single.b2", 8'hCC, 1'b0, 1'b0); step();
        check_beat("single.b3", 8'hDD, 1'b1, 1'b1); step();
        check("single.end", 32'(rd_vld), 32'd0);
        check("single.ready", 32'(wr_ready), 32'd1);

        // Streaming three words, wr_vld held while words remain
        words[0] = 32'h01020304; words[1] = 32'h05060708; words[2] = 32'h090A0B0C;
        ready_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        w = 0;
        wr_data = words[0]; wr_cnt = 2'd3; wr_last = 1'b0; wr_vld = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            hs = wr_vld && wr_ready;
            step();
            if (hs) begin
                w++;
                if (w < 3) wr_data = words[w];
                else wr_vld = 1'b0;
            end
            check($sformatf("stream.ready%0d", k), 32'(wr_ready), 32'(ready_exp[k]));
            if (k <= 12) begin
                check($sformatf("stream.vld%0d", k), 32'(rd_vld), 32'd1);
                check($sformatf("stream.data%0d", k), 32'(rd_data), k);
                check($sformatf("stream.align%0d", k), 32'(rd_align_last), 32'((k % 4) == 0));
            end else begin
                check("stream.end", 32'(rd_vld), 32'd0);
            end
        end

        // Short words: cnt=1 then cnt=0
        wr_data = 32'h11223344; wr_cnt = 2'd1; wr_last = 1'b0; wr_vld = 1'b1;
        step();
        wr_data = 32'h55667788; wr_cnt = 2'd0; wr_last = 1'b1;
        check_beat("short.b0", 8'h11, 1'b0, 1'b0);
        step();
        wr_vld = 1'b0;
        check_beat("short.b1", 8'h22, 1'b1, 1'b0);
        check("short.ready", 32'(wr_ready), 32'd0);
        step();
        check_beat("short.c0", 8'h55, 1'b1, 1'b1);
        step();
        check("short.end", 32'(rd_vld), 32'd0);

        // Backpressure with two words queued
        wr_data = 32'hAABBCCDD; wr_cnt = 2'd3; wr_last = 1'b0; wr_vld = 1'b1;
        step();
        wr_data = 32'h10203040; wr_last = 1'b1;
        check_beat("bp.b0", 8'hAA, 1'b0, 1'b0);
        step();
        wr_vld = 1'b0; rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp.hold%0d.data", k), 32'(rd_data), 32'hBB);
            check($sformatf("bp.hold%0d.vld", k), 32'(rd_vld), 32'd1);
            check($sformatf("bp.hold%0d.align", k), 32'(rd_align_last), 32'd0);
            check($sformatf("bp.hold%0d.ready", k), 32'(wr_ready), 32'd0);
            step();
        end
        check("bp.hold5.data", 32'(rd_data), 32'hBB);
        rd_ready = 1'b1;
        step();
        check_beat("bp.b2", 8'hCC, 1'b0, 1'b0); step();
        check_beat("bp.b3", 8'hDD, 1'b1, 1'b0); step();
        check_beat("bp.c0", 8'h10, 1'b0, 1'b0); step();
        check_beat("bp.c1", 8'h20, 1'b0, 1'b0); step();
        check_beat("bp.c2", 8'h30, 1'b0, 1'b0); step();
        check_beat("bp.c3", 8'h40, 1'b1, 1'b1); step();
        check("bp.end", 32'(rd_vld), 32'd0);

        // Reset mid-word
        wr_data = 32'hAABBCCDD; wr_cnt = 2'd3; wr_last = 1'b1; wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        step();
        step();
        check_beat("mid.b2", 8'hCC, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid.vld", 32'(rd_vld), 32'd0);
        check("mid.data", 32'(rd_data), 32'd0);
        check("mid.ready", 32'(wr_ready), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("mid.idle%0d", k), 32'(rd_vld), 32'd0);
        end
        wr_data = 32'h01020304; wr_cnt = 2'd0; wr_last = 1'b0; wr_vld = 1'b1;
        step();
        wr_vld = 1'b0;
        check_beat("mid.new", 8'h01, 1'b1, 1'b0);
        step();
        check("mid.end", 32'(rd_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_split.md
Name: fifo_split

Overview:
- Width splitter: accepts one DSIZE*NSIZE-bit word per handshake and emits it as up to NSIZE DSIZE-bit beats, one beat per cycle.
- Mirror stage of the width combiner. Beat order matches the combiner's packing, so split followed by combine is the identity.
- Supports short words and word/packet end markers.
- Two-entry ping-pong word buffer, so back-to-back words stream with no bubbles.

Parameters:
- DSIZE, 1, beat width in bits.
- NSIZE, 8, beats per full word; legal range 2..256.
- MSB_FIRST, 1, 1: beat 0 = wr_data[DSIZE*NSIZE-1 -: DSIZE]; 0: beat 0 = wr_data[DSIZE-1:0].

Ports:
- clock  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_data  input  DSIZE*NSIZE  wide word in.
- wr_vld  input  1  word valid.
- wr_ready  output  1  word accepted when wr_vld && wr_ready at a clock edge.
- wr_cnt  input  CSIZE  number of valid beats minus 1; CSIZE = max(1, clog2(NSIZE)).
- wr_last  input  1  word ends a packet.
- rd_data  output  DSIZE  current beat.
- rd_vld  output  1  beat valid.
- rd_ready  input  1  beat consumed when rd_vld && rd_ready at a clock edge.
- rd_align_last  output  1  current beat is the final beat of its word.
- rd_last  output  1  rd_align_last && stored wr_last of that word.

Behaviour:
- Reset (async assert) clears occupancy, ptrs, beat counter and all outputs: rd_vld=0, rd_data=0, rd_align_last=0, rd_last=0, wr_ready=0. Buffer contents are don't-care.
- wr_ready is registered: 0 in reset; next = (next_occupancy != FULL). It is 1 at the first edge after reset release.
- Occupancy FSM: EMPTY -> ONE on push; ONE -> FULL on push without final pop; ONE -> EMPTY on final pop without push; ONE stays ONE on push plus final pop; FULL -> ONE on final pop. No push is possible in FULL because wr_ready=0.
- Push stores {wr_data, sat(wr_cnt), wr_last} at wr_ptr, then toggles wr_ptr. sat() clamps wr_cnt > NSIZE-1 to NSIZE-1.
- rd_vld = (occupancy != EMPTY).
- rd_data, rd_align_last and rd_last are muxed from the head entry using registered state only; there is no combinational path from wr_* to rd_*.
- Latency: word pushed at edge N -> beat 0 presented in the cycle after edge N, when the buffer was EMPTY.
- Beat index b counts 0..cnt. Pop with b<cnt: b <= b+1. Final pop (b==cnt): b <= 0, rd_ptr toggles, and the next entry's beat 0 is presented the next cycle with no bubble.
- rd_align_last = rd_vld && (b == cnt of head).
- wr_cnt=0 gives a single-beat word with rd_align_last=1 on that beat.
- rd_ready low holds b, rd_data and all flags stable. rd_vld never drops without a pop.
- Throughput: 1 beat/cycle sustained. A word stream with cnt=NSIZE-1 keeps wr_ready duty at 1/NSIZE once FULL.
- Reset mid-word discards all pending beats; no partial word is emitted after release.

Decomposition:
- Package fifo_hdl_pkg holds:
  - clog2 function and the CSIZE derivation;
  - occupancy enum typedef {EMPTY, ONE, FULL};
  - beat-slice helper function (index -> bit offset, honours MSB_FIRST).
- Natural sub-module: fifo_word_buf2, the 2-entry ping-pong store with wr_ptr/rd_ptr and occupancy. Its outputs are head word, cnt and last. fifo_split adds the beat counter and the output mux.

Test Plan:
All tests use DSIZE=8, NSIZE=4, MSB_FIRST=1.
- Reset: rst_n=0 -> rd_vld=0, wr_ready=0, rd_data=0. Release -> wr_ready=1 after first edge, rd_vld stays 0.
- Single word: push 0xAABBCCDD, cnt=3, last=1, rd_ready=1 -> beats AA,BB,CC,DD on cycles 1-4; rd_align_last=rd_last=1 only on DD; rd_vld=0 on cycle 5.
- Streaming: words 0x01020304, 0x05060708, 0x090A0B0C, wr_vld held, rd_ready=1 -> 12 contiguous beats 01..0C with no bubble. wr_ready=0 after the second push and back to 1 the cycle after 04 pops.
- Short word: push 0x11223344 cnt=1, then 0x55667788 cnt=0 -> beats 11, 22(align_last), 55(align_last). Data bytes 33, 44, 66, 77, 88 are never emitted.
- Backpressure: rd_ready=0 for 5 cycles while beat BB is showing -> rd_data=BB, rd_vld=1 and b stable throughout; wr_ready=0 once two words are queued. Release -> CC follows next cycle.
- Reset mid-word: assert rst_n=0 while beat CC is showing -> rd_vld=0 immediately; after release no beat appears until a new push.
